mul8_sched: RTL and testbench

- Shares one combinational 8x8 partial-product compressor tree (`compressor`: 15 input columns src0..src14, 16 single-bit outputs dst0..dst15) among N_REQ requesters.
- Round-robin arbitrates one operation per cycle and generates the AND-array partial-product columns.
- Registers the 16-bit product and optionally folds it into a per-requester accumulator.
- Sits between DSP-lite clients and the compressor datapath; the compressor stays purely combinational.

---
 rtl/mul_sched_pkg.sv | 27 ++
 rtl/compressor.sv | 51 +++++
 rtl/mul_sched_rr_arb.sv | 41 ++++
 rtl/mul8_sched.sv | 169 ++++++++++++++++
 tb/tb_mul8_sched.sv | 397 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mul_sched_pkg.sv
// mul_sched_pkg: op encodings, widths and the 8x8 partial-product column geometry
// shared by the mul8_sched scheduler, its arbiter and the compressor.
package mul_sched_pkg;

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_MAC  = 2'b01;
  localparam logic [1:0] OP_LOAD = 2'b10;
  localparam logic [1:0] OP_RSV  = 2'b11;

  localparam int ACC_W_DEF = 24;
  localparam int PROD_W    = 16;
  localparam int N_COLS    = 15;
  localparam int PP_BITS   = 64;

  function automatic int col_height(input int c);
    return (c < 8) ? c + 1 : 15 - c;
  endfunction

  // Offset of column c inside the flat 64-bit partial-product vector.
  function automatic int col_base(input int c);
    int s;
    s = 0;
    for (int k = 0; k < c; k++) s = s + col_height(k);
    return s;
  endfunction

endpackage

// File: rtl/compressor.sv
// compressor: purely combinational 8x8 partial-product column compressor.
// Column c holds bits of weight 2^c; the 16 outputs form the product.
module compressor
  import mul_sched_pkg::*;
(
  input  logic [col_height(0)-1:0]  src0,
  input  logic [col_height(1)-1:0]  src1,
  input  logic [col_height(2)-1:0]  src2,
  input  logic [col_height(3)-1:0]  src3,
  input  logic [col_height(4)-1:0]  src4,
  input  logic [col_height(5)-1:0]  src5,
  input  logic [col_height(6)-1:0]  src6,
  input  logic [col_height(7)-1:0]  src7,
  input  logic [col_height(8)-1:0]  src8,
  input  logic [col_height(9)-1:0]  src9,
  input  logic [col_height(10)-1:0] src10,
  input  logic [col_height(11)-1:0] src11,
  input  logic [col_height(12)-1:0] src12,
  input  logic [col_height(13)-1:0] src13,
  input  logic [col_height(14)-1:0] src14,
  output logic dst0,  output logic dst1,  output logic dst2,  output logic dst3,
  output logic dst4,  output logic dst5,  output logic dst6,  output logic dst7,
  output logic dst8,  output logic dst9,  output logic dst10, output logic dst11,
  output logic dst12, output logic dst13, output logic dst14, output logic dst15
);

  logic [PROD_W-1:0] w_sum;

  always_comb begin
    w_sum = '0;
    w_sum = w_sum + (PROD_W'($countones(src0)));
    w_sum = w_sum + (PROD_W'($countones(src1))  << 1);
    w_sum = w_sum + (PROD_W'($countones(src2))  << 2);
    w_sum = w_sum + (PROD_W'($countones(src3))  << 3);
    w_sum = w_sum + (PROD_W'($countones(src4))  << 4);
    w_sum = w_sum + (PROD_W'($countones(src5))  << 5);
    w_sum = w_sum + (PROD_W'($countones(src6))  << 6);
    w_sum = w_sum + (PROD_W'($countones(src7))  << 7);
    w_sum = w_sum + (PROD_W'($countones(src8))  << 8);
    w_sum = w_sum + (PROD_W'($countones(src9))  << 9);
    w_sum = w_sum + (PROD_W'($countones(src10)) << 10);
    w_sum = w_sum + (PROD_W'($countones(src11)) << 11);
    w_sum = w_sum + (PROD_W'($countones(src12)) << 12);
    w_sum = w_sum + (PROD_W'($countones(src13)) << 13);
    w_sum = w_sum + (PROD_W'($countones(src14)) << 14);
  end

  assign {dst15, dst14, dst13, dst12, dst11, dst10, dst9, dst8,
          dst7, dst6, dst5, dst4, dst3, dst2, dst1, dst0} = w_sum;

endmodule

// File: rtl/mul_sched_rr_arb.sv
// mul_sched_rr_arb: N-way round-robin arbiter. The pointer moves past the
// granted requester only when the grant is actually taken (i_adv high).
module mul_sched_rr_arb #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  i_req,
  input  logic          i_adv,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  logic [IW-1:0] r_ptr;

  always_comb begin
    logic [IW-1:0] v_j;
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    v_j     = '0;
    for (int k = 0; k < N; k++) begin
      v_j = IW'((int'(r_ptr) + k) % N);
      if (!o_any && i_req[v_j]) begin
        o_any        = 1'b1;
        o_grant[v_j] = 1'b1;
        o_idx        = v_j;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_ptr <= '0;
    else if (i_adv && o_any)
      r_ptr <= (o_idx == IW'(N - 1)) ? '0 : o_idx + 1'b1;
  end

endmodule

// File: rtl/mul8_sched.sv
// mul8_sched: round-robin scheduler sharing one 8x8 compressor among N_REQ clients,
// with per-requester accumulators. Optional self-check: MUL_SCHED_SELFCHECK_EN.
module mul8_sched
  import mul_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ACC_W = ACC_W_DEF,
  parameter int ID_W  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ*8-1:0] req_a,
  input  logic [N_REQ*8-1:0] req_b,
  input  logic [N_REQ*2-1:0] req_op,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [ID_W-1:0]    resp_id,
  output logic [ACC_W-1:0]   resp_data,
  output logic               busy,
  output logic               err
);

  logic [N_REQ-1:0]  w_grant;
  logic [ID_W-1:0]   w_idx;
  logic              w_any;
  logic              w_adv;
  logic [7:0]        w_a, w_b;
  logic [1:0]        w_op;
  logic              r_s1_valid;
  logic [7:0]        r_s1_a, r_s1_b;
  logic [1:0]        r_s1_op;
  logic [ID_W-1:0]   r_s1_id;
  logic [PP_BITS-1:0] w_pp;
  logic [PROD_W-1:0] w_p;
  logic [ACC_W-1:0]  w_pext, w_mac;
  logic              r_resp_valid;
  logic [ID_W-1:0]   r_resp_id;
  logic [ACC_W-1:0]  r_resp_data;
  logic [ACC_W-1:0]  r_acc [N_REQ];

  assign w_adv     = !r_resp_valid || resp_ready;
  assign req_ready = (rst_n && w_adv) ? w_grant : '0;

  mul_sched_rr_arb #(.N(N_REQ), .IW(ID_W)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_req   (req_valid),
    .i_adv   (w_adv),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  always_comb begin
    w_a  = '0;
    w_b  = '0;
    w_op = OP_MUL;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_grant[i]) begin
        w_a  = req_a[i*8 +: 8];
        w_b  = req_b[i*8 +: 8];
        w_op = req_op[i*2 +: 2];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_op    <= OP_MUL;
      r_s1_id    <= '0;
    end else if (w_adv) begin
      r_s1_valid <= w_any;
      if (w_any) begin
        r_s1_a  <= w_a;
        r_s1_b  <= w_b;
        r_s1_op <= w_op;
        r_s1_id <= w_idx;
      end
    end
  end

  // Column c carries a[i]&b[j] for i+j=c, packed with i ascending from the column base.
  always_comb begin
    w_pp = '0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        w_pp[col_base(i + j) + ((i + j > 7) ? 7 - j : i)] = r_s1_a[i] & r_s1_b[j];
  end

  compressor u_comp (
    .src0  (w_pp[col_base(0)  +: col_height(0)]),
    .src1  (w_pp[col_base(1)  +: col_height(1)]),
    .src2  (w_pp[col_base(2)  +: col_height(2)]),
    .src3  (w_pp[col_base(3)  +: col_height(3)]),
    .src4  (w_pp[col_base(4)  +: col_height(4)]),
    .src5  (w_pp[col_base(5)  +: col_height(5)]),
    .src6  (w_pp[col_base(6)  +: col_height(6)]),
    .src7  (w_pp[col_base(7)  +: col_height(7)]),
    .src8  (w_pp[col_base(8)  +: col_height(8)]),
    .src9  (w_pp[col_base(9)  +: col_height(9)]),
    .src10 (w_pp[col_base(10) +: col_height(10)]),
    .src11 (w_pp[col_base(11) +: col_height(11)]),
    .src12 (w_pp[col_base(12) +: col_height(12)]),
    .src13 (w_pp[col_base(13) +: col_height(13)]),
    .src14 (w_pp[col_base(14) +: col_height(14)]),
    .dst0  (w_p[0]),  .dst1  (w_p[1]),  .dst2  (w_p[2]),  .dst3  (w_p[3]),
    .dst4  (w_p[4]),  .dst5  (w_p[5]),  .dst6  (w_p[6]),  .dst7  (w_p[7]),
    .dst8  (w_p[8]),  .dst9  (w_p[9]),  .dst10 (w_p[10]), .dst11 (w_p[11]),
    .dst12 (w_p[12]), .dst13 (w_p[13]), .dst14 (w_p[14]), .dst15 (w_p[15])
  );

  assign w_pext = ACC_W'(w_p);
  assign w_mac  = r_acc[r_s1_id] + w_pext;

  // Accumulators are read and written only here, so consecutive MACs see fresh values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resp_valid <= 1'b0;
      r_resp_id    <= '0;
      r_resp_data  <= '0;
      for (int i = 0; i < N_REQ; i++) r_acc[i] <= '0;
    end else if (w_adv) begin
      r_resp_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_resp_id <= r_s1_id;
        case (r_s1_op)
          OP_MAC: begin
            r_acc[r_s1_id] <= w_mac;
            r_resp_data    <= w_mac;
          end
          OP_LOAD: begin
            r_acc[r_s1_id] <= w_pext;
            r_resp_data    <= w_pext;
          end
          OP_MUL, OP_RSV: r_resp_data <= w_pext;
        endcase
      end
    end
  end

  assign resp_valid = r_resp_valid;
  assign resp_id    = r_resp_id;
  assign resp_data  = r_resp_data;
  assign busy       = r_s1_valid | r_resp_valid;

`ifdef MUL_SCHED_SELFCHECK_EN
  logic [PROD_W-1:0] w_ref;
  logic              r_err;

  assign w_ref = PROD_W'(r_s1_a) * PROD_W'(r_s1_b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_err <= 1'b0;
    else if (w_adv && r_s1_valid && (w_ref != w_p))
      r_err <= 1'b1;
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mul8_sched.sv
// tb_mul8_sched: randomized self-checking bench for mul8_sched against a
// transaction-level model (round-robin rule, in-order result queue, accumulators).
module tb_mul8_sched;
  import mul_sched_pkg::*;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid, req_ready;
  logic [N*8-1:0] req_a, req_b;
  logic [N*2-1:0] req_op;
  logic           resp_valid, resp_ready;
  logic [1:0]     resp_id;
  logic [23:0]    resp_data;
  logic           busy, err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mul8_sched #(.N_REQ(N), .ACC_W(24), .ID_W(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_data  (resp_data),
    .busy       (busy),
    .err        (err)
  );

  // Reference model: queue of accepted transactions in order, each either
  // waiting in the first stage (stage 1) or presented as a response (stage 2).
  typedef struct {
    logic [1:0]  id;
    logic [23:0] data;
    int          stage;
  } item_t;

  item_t       q[$];
  logic [23:0] m_acc [N];
  int          m_ptr;

  logic [N-1:0] exp_rdy, obs_rdy;
  logic         exp_rv, obs_rv, exp_busy, obs_busy, obs_err;
  logic [1:0]   exp_id, obs_id;
  logic [23:0]  exp_data, obs_data;
  int           acc_idx;

  task automatic model_clear();
    q.delete();
    for (int i = 0; i < N; i++) m_acc[i] = '0;
    m_ptr = 0;
  endtask

  task automatic set_req(input int i, input bit v, input logic [7:0] a,
                         input logic [7:0] b, input logic [1:0] op);
    req_valid[i]     = v;
    req_a[i*8 +: 8]  = a;
    req_b[i*8 +: 8]  = b;
    req_op[i*2 +: 2] = op;
  endtask

  task automatic rnd_req(input int i, input logic [1:0] op);
    set_req(i, 1'b1, 8'($urandom), 8'($urandom), op);
  endtask

  // Advance one clock: predict this cycle's outputs, sample the DUT, update model.
  task automatic tick();
    bit adv;
    int g;
    item_t it;
    logic [23:0] p;
    logic [1:0] op;
    #1;
    exp_rv = (q.size() > 0) && (q[0].stage == 2);
    adv    = !exp_rv || resp_ready;
    g      = -1;
    for (int k = 0; k < N; k++) begin
      int j = (m_ptr + k) % N;
      if (g < 0 && req_valid[j]) g = j;
    end
    exp_rdy = '0;
    if (adv && g >= 0) exp_rdy[g] = 1'b1;
    exp_id   = exp_rv ? q[0].id : 2'd0;
    exp_data = exp_rv ? q[0].data : 24'd0;
    exp_busy = (q.size() > 0);
    obs_rdy  = req_ready;
    obs_rv   = resp_valid;
    obs_id   = resp_id;
    obs_data = resp_data;
    obs_busy = busy;
    obs_err  = err;
    acc_idx  = (adv && g >= 0) ? g : -1;
    p  = '0;
    op = '0;
    if (acc_idx >= 0) begin
      p  = 24'(req_a[g*8 +: 8]) * 24'(req_b[g*8 +: 8]);
      op = req_op[g*2 +: 2];
    end
    @(posedge clk);
    if (adv) begin
      if (exp_rv) void'(q.pop_front());
      foreach (q[i]) q[i].stage = 2;
      if (acc_idx >= 0) begin
        it.id    = 2'(g);
        it.stage = 1;
        if (op == OP_MAC) begin
          m_acc[g] = m_acc[g] + p;
          it.data  = m_acc[g];
        end else if (op == OP_LOAD) begin
          m_acc[g] = p;
          it.data  = p;
        end else begin
          it.data = p;
        end
        q.push_back(it);
        m_ptr = (g + 1) % N;
      end
    end
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n      = 1'b0;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    req_op     = '0;
    resp_ready = 1'b1;
    @(negedge clk);
    model_clear();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    resp_ready = 1'b1;
    req_a      = '1;
    req_b      = '1;
    req_op     = '0;
    req_valid  = '1;
    #3;
    total++; if (req_ready !== 4'b0) begin bad++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    total++; if ({resp_valid, resp_id, resp_data} !== 27'd0) begin bad++;
      $display("FAIL reset_resp: got v=%b id=%0d data=%h want all zero", resp_valid, resp_id, resp_data); end
    total++; if ({busy, err} !== 2'b00) begin bad++; $display("FAIL reset_flags: got busy=%b err=%b want 0 0", busy, err); end
    @(negedge clk);
    @(negedge clk);
    total++; if ({busy, resp_valid, req_ready} !== 6'd0) begin bad++;
      $display("FAIL reset_hold: got busy=%b rv=%b rdy=%b want zeros", busy, resp_valid, req_ready); end
    apply_reset();
  endtask

  task automatic test_single_mul();
    apply_reset();
    set_req(0, 1'b1, 8'hFF, 8'hFF, OP_MUL);
    tick();
    total++; if (obs_rdy !== 4'b0001) begin bad++; $display("FAIL single_accept: got %b want 0001", obs_rdy); end
    set_req(0, 1'b0, 8'h00, 8'h00, OP_MUL);
    tick();
    total++; if (obs_rv !== 1'b0 || obs_busy !== 1'b1) begin bad++;
      $display("FAIL single_mid: got rv=%b busy=%b want rv=0 busy=1", obs_rv, obs_busy); end
    tick();
    total++; if ({obs_rv, obs_id, obs_data} !== {1'b1, 2'd0, 24'h00FE01}) begin bad++;
      $display("FAIL single_resp: got v=%b id=%0d data=%h want v=1 id=0 data=00fe01", obs_rv, obs_id, obs_data); end
    total++; if (obs_err !== 1'b0) begin bad++; $display("FAIL single_err: got %b want 0", obs_err); end
    tick();
  endtask

  task automatic test_round_robin();
    apply_reset();
    for (int i = 0; i < N; i++) rnd_req(i, OP_MUL);
    for (int c = 0; c < 16; c++) begin
      tick();
      total++; if (acc_idx !== c % N || obs_rdy !== exp_rdy) begin bad++;
        $display("FAIL rr_grant: cycle %0d got ready=%b want ready=%b (grant %0d)", c, obs_rdy, exp_rdy, c % N); end
      total++; if (obs_rv !== exp_rv || (exp_rv && {obs_id, obs_data} !== {exp_id, exp_data})) begin bad++;
        $display("FAIL rr_resp: got v=%b id=%0d data=%h want v=%b id=%0d data=%h", obs_rv, obs_id, obs_data, exp_rv, exp_id, exp_data); end
      if (acc_idx >= 0) rnd_req(acc_idx, OP_MUL);
    end
    req_valid = '0;
    repeat (3) tick();
  endtask

  task automatic test_mac_seq();
    logic [1:0]  op_l [3];
    logic [7:0]  a_l  [3];
    logic [7:0]  b_l  [3];
    logic [23:0] want [3];
    int sent, got;
    op_l = '{OP_LOAD, OP_MAC, OP_MAC};
    a_l  = '{8'd3, 8'h10, 8'hFF};
    b_l  = '{8'd5, 8'h10, 8'hFF};
    want = '{24'd15, 24'd271, 24'd65296};
    sent = 0;
    got  = 0;
    apply_reset();
    set_req(2, 1'b1, a_l[0], b_l[0], op_l[0]);
    for (int c = 0; c < 20 && got < 3; c++) begin
      tick();
      total++; if (obs_rdy !== exp_rdy || obs_rv !== exp_rv || (exp_rv && obs_data !== exp_data)) begin bad++;
        $display("FAIL mac_model: got rdy=%b v=%b data=%h want rdy=%b v=%b data=%h", obs_rdy, obs_rv, obs_data, exp_rdy, exp_rv, exp_data); end
      if (obs_rv && resp_ready) begin
        total++; if ({obs_id, obs_data} !== {2'd2, want[got]}) begin bad++;
          $display("FAIL mac_seq%0d: got id=%0d data=%0d want id=2 data=%0d", got, obs_id, obs_data, want[got]); end
        got++;
      end
      if (acc_idx == 2) begin
        sent++;
        if (sent < 3) set_req(2, 1'b1, a_l[sent], b_l[sent], op_l[sent]);
        else set_req(2, 1'b0, 8'd0, 8'd0, OP_MUL);
      end
    end
    total++; if (got != 3) begin bad++; $display("FAIL mac_timeout: got %0d responses want 3", got); end
    set_req(2, 1'b1, 8'd0, 8'd0, OP_MAC);
    got = 0;
    for (int c = 0; c < 10 && got < 1; c++) begin
      tick();
      if (acc_idx == 2) set_req(2, 1'b0, 8'd0, 8'd0, OP_MUL);
      if (obs_rv && resp_ready) begin
        total++; if (obs_data !== 24'h00FF10) begin bad++; $display("FAIL mac_acc2: got %h want 00ff10", obs_data); end
        got++;
      end
    end
    total++; if (got != 1) begin bad++; $display("FAIL mac_acc_timeout: got %0d responses want 1", got); end
  endtask

  task automatic test_backpressure();
    logic [1:0] ids [$];
    logic [1:0] want_ids [4];
    want_ids = '{2'd1, 2'd3, 2'd0, 2'd2};
    apply_reset();
    rnd_req(1, OP_MUL);
    rnd_req(3, OP_LOAD);
    tick();
    set_req(1, 1'b0, 8'd0, 8'd0, OP_MUL);
    tick();
    set_req(3, 1'b0, 8'd0, 8'd0, OP_MUL);
    resp_ready = 1'b0;
    rnd_req(0, OP_MAC);
    rnd_req(2, OP_MUL);
    for (int c = 0; c < 5; c++) begin
      tick();
      total++; if (obs_rdy !== 4'b0000 || acc_idx != -1) begin bad++; $display("FAIL bp_ready: cycle %0d got %b want 0000", c, obs_rdy); end
      total++; if ({obs_rv, obs_busy} !== 2'b11 || {obs_id, obs_data} !== {exp_id, exp_data}) begin bad++;
        $display("FAIL bp_hold: got v=%b busy=%b id=%0d data=%h want v=1 busy=1 id=%0d data=%h", obs_rv, obs_busy, obs_id, obs_data, exp_id, exp_data); end
    end
    resp_ready = 1'b1;
    for (int c = 0; c < 20 && ids.size() < 4; c++) begin
      tick();
      if (c == 0) begin
        total++; if (obs_rdy !== 4'b0001) begin bad++; $display("FAIL bp_ptr: got ready=%b want 0001", obs_rdy); end
      end
      total++; if (obs_rv !== exp_rv || (exp_rv && {obs_id, obs_data} !== {exp_id, exp_data})) begin bad++;
        $display("FAIL bp_resp: got v=%b id=%0d data=%h want v=%b id=%0d data=%h", obs_rv, obs_id, obs_data, exp_rv, exp_id, exp_data); end
      if (acc_idx >= 0) set_req(acc_idx, 1'b0, 8'd0, 8'd0, OP_MUL);
      if (obs_rv) ids.push_back(obs_id);
    end
    total++; if (ids.size() != 4) begin bad++; $display("FAIL bp_count: got %0d responses want 4", ids.size()); end
    for (int i = 0; i < 4 && i < ids.size(); i++) begin
      total++; if (ids[i] !== want_ids[i]) begin bad++; $display("FAIL bp_order%0d: got id=%0d want id=%0d", i, ids[i], want_ids[i]); end
    end
  endtask

  task automatic test_wrap();
    int sent, got;
    logic [23:0] last [2];
    sent = 0;
    got  = 0;
    last = '{24'd0, 24'd0};
    apply_reset();
    set_req(1, 1'b1, 8'hFF, 8'd3, OP_LOAD);
    for (int c = 0; c < 400 && got < 260; c++) begin
      tick();
      total++; if (obs_rdy !== exp_rdy || obs_rv !== exp_rv || (exp_rv && obs_data !== exp_data)) begin bad++;
        $display("FAIL wrap_model: got rdy=%b v=%b data=%h want rdy=%b v=%b data=%h", obs_rdy, obs_rv, obs_data, exp_rdy, exp_rv, exp_data); end
      if (obs_rv) begin
        last[0] = last[1];
        last[1] = obs_data;
        got++;
      end
      if (acc_idx == 1) begin
        sent++;
        if (sent < 259) set_req(1, 1'b1, 8'hFF, 8'hFF, OP_MAC);
        else if (sent == 259) set_req(1, 1'b1, 8'h01, 8'h02, OP_MAC);
        else set_req(1, 1'b0, 8'd0, 8'd0, OP_MUL);
      end
    end
    total++; if (got != 260) begin bad++; $display("FAIL wrap_timeout: got %0d responses want 260", got); end
    total++; if (last[0] !== 24'hFFFFFF) begin bad++; $display("FAIL wrap_full: got %h want ffffff", last[0]); end
    total++; if (last[1] !== 24'h000001) begin bad++; $display("FAIL wrap_result: got %h want 000001", last[1]); end
  endtask

  task automatic test_reset_midop();
    logic [7:0] a, b;
    int got;
    apply_reset();
    set_req(1, 1'b1, 8'hC3, 8'h7E, OP_LOAD);
    for (int c = 0; c < 4; c++) begin
      tick();
      if (acc_idx == 1) set_req(1, 1'b0, 8'd0, 8'd0, OP_MUL);
    end
    resp_ready = 1'b0;
    rnd_req(1, OP_MAC);
    rnd_req(0, OP_MUL);
    repeat (3) tick();
    total++; if ({obs_rv, obs_busy, obs_rdy} !== 6'b110000) begin bad++;
      $display("FAIL midrst_setup: got v=%b busy=%b rdy=%b want v=1 busy=1 rdy=0000", obs_rv, obs_busy, obs_rdy); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if ({resp_valid, resp_id, resp_data, busy, err, req_ready} !== 33'd0) begin bad++;
      $display("FAIL midrst_clear: got v=%b id=%0d data=%h busy=%b err=%b rdy=%b want zeros", resp_valid, resp_id, resp_data, busy, err, req_ready); end
    @(negedge clk);
    model_clear();
    req_valid  = '0;
    rst_n      = 1'b1;
    resp_ready = 1'b1;
    a = 8'($urandom);
    b = 8'($urandom);
    set_req(1, 1'b1, a, b, OP_MAC);
    got = 0;
    for (int c = 0; c < 10 && got < 1; c++) begin
      tick();
      if (acc_idx == 1) set_req(1, 1'b0, 8'd0, 8'd0, OP_MUL);
      if (obs_rv) begin
        total++; if ({obs_id, obs_data} !== {2'd1, 24'(a) * 24'(b)}) begin bad++;
          $display("FAIL midrst_mac: got id=%0d data=%h want id=1 data=%h", obs_id, obs_data, 24'(a) * 24'(b)); end
        got++;
      end
    end
    total++; if (got != 1) begin bad++; $display("FAIL midrst_timeout: got %0d responses want 1", got); end
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 300; c++) begin
      resp_ready = ($urandom_range(0, 3) != 0);
      tick();
      total++; if (obs_rdy !== exp_rdy || obs_busy !== exp_busy || obs_err !== 1'b0) begin bad++;
        $display("FAIL rnd_ctrl: cycle %0d got rdy=%b busy=%b err=%b want rdy=%b busy=%b err=0", c, obs_rdy, obs_busy, obs_err, exp_rdy, exp_busy); end
      total++; if (obs_rv !== exp_rv || (exp_rv && {obs_id, obs_data} !== {exp_id, exp_data})) begin bad++;
        $display("FAIL rnd_resp: cycle %0d got v=%b id=%0d data=%h want v=%b id=%0d data=%h", c, obs_rv, obs_id, obs_data, exp_rv, exp_id, exp_data); end
      for (int i = 0; i < N; i++) begin
        if (i == acc_idx || !req_valid[i]) begin
          if ($urandom_range(0, 1) == 1) rnd_req(i, 2'($urandom_range(0, 3)));
          else set_req(i, 1'b0, 8'd0, 8'd0, OP_MUL);
        end else if ($urandom_range(0, 15) == 0) begin
          set_req(i, 1'b0, 8'd0, 8'd0, OP_MUL);
        end
      end
    end
    req_valid  = '0;
    resp_ready = 1'b1;
    for (int c = 0; c < 10 && q.size() > 0; c++) begin
      tick();
      total++; if (obs_rv !== exp_rv || (exp_rv && {obs_id, obs_data} !== {exp_id, exp_data})) begin bad++;
        $display("FAIL rnd_drain: got v=%b id=%0d data=%h want v=%b id=%0d data=%h", obs_rv, obs_id, obs_data, exp_rv, exp_id, exp_data); end
    end
    total++; if (q.size() != 0) begin bad++; $display("FAIL rnd_drain_timeout: got %0d pending want 0", q.size()); end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n      = 1'b0;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    req_op     = '0;
    resp_ready = 1'b1;
    model_clear();
    test_reset();
    test_single_mul();
    test_round_robin();
    test_mac_seq();
    test_backpressure();
    test_wrap();
    test_reset_midop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
